// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, arithmetic shift, rotate, load and clear.
// Runs either one operation per clock (free-running) or as a counted multi-step
// operation started by start/amt and reported through busy/done.
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             ser_in_l,
   input  logic             ser_in_r,
   input  logic [WIDTH-1:0] par_in,
   input  logic             start,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qn,
   output logic             ser_out_l,
   output logic             ser_out_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic [2:0] {
      OP_HOLD  = 3'b000,
      OP_SHL   = 3'b001,
      OP_SHR   = 3'b010,
      OP_LOAD  = 3'b011,
      OP_ROTL  = 3'b100,
      OP_ROTR  = 3'b101,
      OP_ASR   = 3'b110,
      OP_CLEAR = 3'b111
   } op_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   op_e              op_q, op_d;
   state_e           state_q, state_d;
   logic             done_q, done_d;

   // One step of the selected operation applied to the current contents.
   function automatic logic [WIDTH-1:0] step_fn(
      input op_e              op,
      input logic [WIDTH-1:0] cur,
      input logic             sl,
      input logic             sr,
      input logic [WIDTH-1:0] par
   );
      logic [WIDTH-1:0] r;
      r = cur;
      case (op)
         OP_HOLD:  r = cur;
         OP_SHL:   r = {cur[WIDTH-2:0], sr};
         OP_SHR:   r = {sl, cur[WIDTH-1:1]};
         OP_LOAD:  r = par;
         OP_ROTL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
         OP_ROTR:  r = {cur[0], cur[WIDTH-1:1]};
         OP_ASR:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
         OP_CLEAR: r = '0;
         default:  r = cur;
      endcase
      return r;
   endfunction

   // Next-state logic: free-running steps, counted-operation launch and RUN stepping.
   always_comb begin
      q_d     = q_q;
      rem_d   = rem_q;
      op_d    = op_q;
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d = op_e'(mode);
               if (amt == '0) begin
                  done_d = 1'b1;
               end else if (op_e'(mode) == OP_HOLD || op_e'(mode) == OP_LOAD ||
                            op_e'(mode) == OP_CLEAR) begin
                  // Non-shifting ops are idempotent, so they finish in one edge.
                  q_d    = step_fn(op_e'(mode), q_q, ser_in_l, ser_in_r, par_in);
                  done_d = 1'b1;
               end else begin
                  q_d   = step_fn(op_e'(mode), q_q, ser_in_l, ser_in_r, par_in);
                  rem_d = amt - AMT_W'(1);
                  if (amt == AMT_W'(1)) begin
                     done_d = 1'b1;
                  end else begin
                     state_d = RUN;
                  end
               end
            end else begin
               q_d = step_fn(op_e'(mode), q_q, ser_in_l, ser_in_r, par_in);
            end
         end
         RUN: begin
            q_d   = step_fn(op_q, q_q, ser_in_l, ser_in_r, par_in);
            rem_d = rem_q - AMT_W'(1);
            if (rem_q == AMT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q     <= '0;
         rem_q   <= '0;
         op_q    <= OP_HOLD;
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         q_q     <= q_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Outputs derived purely from registered state.
   always_comb begin
      q         = q_q;
      qn        = ~q_q;
      ser_out_l = q_q[WIDTH-1];
      ser_out_r = q_q[0];
      busy      = (state_q == RUN);
      done      = done_q;
   end

endmodule
